// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point in-place FFT: default size, the
// unload FSM encoding and the index/bank/address mapping helpers used by
// both the FFT control block and the output reader.
package fft_pkg;

  localparam int N_LOG2_DEF = 6;
  // Widest index the mapping helpers accept; callers zero-extend.
  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  // Reverse the low w bits of v; bits at or above w come back as zero.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] v,
                                              input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < int'(w)) begin
        r[i] = v[int'(w) - 1 - i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  // Bank select: XOR-reduction of the index (invariant under bit reversal).
  function automatic logic parity(input logic [MAX_W-1:0] v);
    return ^v;
  endfunction

  // Word address inside a bank: natural index without its lowest bit.
  function automatic logic [MAX_W-1:0] addr_of(input logic [MAX_W-1:0] m);
    return {1'b0, m[MAX_W-1:1]};
  endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Two-entry synchronous FIFO with occupancy output. Push and pop may happen
// in the same cycle; reset flushes contents so the head reads as zero.
module fft_out_fifo #(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         not_empty
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         push_ok_s;
  logic         pop_ok_s;

  // Qualify requests so an empty pop or a full push without pop is dropped.
  always_comb begin
    pop_ok_s  = pop && (count_r != 2'd0);
    push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
  end

  // Storage, pointers and occupancy, flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign not_empty = (count_r != 2'd0);

endmodule

// File: rtl/fft_output_reader.sv
// Unloads FFT results from the two bit-reversed banks in natural order
// k = 0..N-1 and streams them on a valid/ready interface. Reads are issued
// only when the output FIFO is guaranteed to have room for the result.
module fft_output_reader
  import fft_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                re_b0,
  output logic [N_LOG2-2:0]   raddr_b0,
  input  logic [DATA_W-1:0]   rdata_b0,
  output logic                re_b1,
  output logic [N_LOG2-2:0]   raddr_b1,
  input  logic [DATA_W-1:0]   rdata_b1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [N_LOG2-1:0]   out_index,
  output logic                out_last
);

  localparam int N      = 1 << N_LOG2;
  localparam int ADDR_W = N_LOG2 - 1;
  localparam int FW     = DATA_W + N_LOG2 + 1;
  localparam logic [N_LOG2-1:0] K_LAST = N_LOG2'(N - 1);

  rd_state_t          state_r, state_nxt_s;
  logic [N_LOG2-1:0]  k_iss_r, k_iss_nxt_s;
  logic               done_r, done_nxt_s;
  logic               rd_pend_r;   // a read result arrives this cycle
  logic               rd_bank_r;   // bank that result comes from
  logic [N_LOG2-1:0]  rd_k_r;      // frequency index of that result
  logic               issue_s;
  logic               pop_s;
  logic               credit_s;
  logic [2:0]         occ_s;
  logic               bank_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [DATA_W-1:0]  rd_data_s;
  logic [FW-1:0]      push_word_s;
  logic [FW-1:0]      head_s;
  logic [1:0]         fifo_count_s;
  logic               fifo_ne_s;

  // Map the issue index to bank and word address, and evaluate read credit.
  always_comb begin
    bank_s   = parity(MAX_W'(k_iss_r));
    addr_s   = ADDR_W'(addr_of(bitrev(MAX_W'(k_iss_r), N_LOG2)));
    pop_s    = fifo_ne_s && out_ready;
    occ_s    = {1'b0, fifo_count_s} + {2'b00, rd_pend_r};
    credit_s = (occ_s < (3'd2 + {2'b00, pop_s}));
  end

  // Unload FSM: next state, issue counter, read issue and done pulse.
  always_comb begin
    state_nxt_s = state_r;
    k_iss_nxt_s = k_iss_r;
    done_nxt_s  = 1'b0;
    issue_s     = 1'b0;
    case (state_r)
      RD_IDLE: begin
        k_iss_nxt_s = '0;
        // A start coinciding with done is not a new request.
        if (start && !done_r) begin
          state_nxt_s = RD_RUN;
        end else begin
          state_nxt_s = RD_IDLE;
        end
      end
      RD_RUN: begin
        if (credit_s) begin
          issue_s = 1'b1;
          if (k_iss_r == K_LAST) begin
            state_nxt_s = RD_DRAIN;
            k_iss_nxt_s = '0;
          end else begin
            k_iss_nxt_s = k_iss_r + N_LOG2'(1);
          end
        end else begin
          k_iss_nxt_s = k_iss_r;
        end
      end
      RD_DRAIN: begin
        if (pop_s && out_last) begin
          state_nxt_s = RD_IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = RD_DRAIN;
        end
      end
      default: begin
        state_nxt_s = RD_IDLE;
      end
    endcase
  end

  // Drive only the selected bank; the idle bank sees address zero.
  always_comb begin
    re_b0    = 1'b0;
    re_b1    = 1'b0;
    raddr_b0 = '0;
    raddr_b1 = '0;
    if (issue_s) begin
      if (bank_s) begin
        re_b1    = 1'b1;
        raddr_b1 = addr_s;
      end else begin
        re_b0    = 1'b1;
        raddr_b0 = addr_s;
      end
    end else begin
      re_b0 = 1'b0;
    end
  end

  // State, counters and the one-cycle read-return pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RD_IDLE;
      k_iss_r   <= '0;
      done_r    <= 1'b0;
      rd_pend_r <= 1'b0;
      rd_bank_r <= 1'b0;
      rd_k_r    <= '0;
    end else begin
      state_r   <= state_nxt_s;
      k_iss_r   <= k_iss_nxt_s;
      done_r    <= done_nxt_s;
      rd_pend_r <= issue_s;
      rd_bank_r <= bank_s;
      rd_k_r    <= k_iss_r;
    end
  end

  // Select the returning bank and pack the sample with its index and last flag.
  always_comb begin
    if (rd_bank_r) begin
      rd_data_s = rdata_b1;
    end else begin
      rd_data_s = rdata_b0;
    end
    push_word_s = {(rd_k_r == K_LAST), rd_k_r, rd_data_s};
  end

  fft_out_fifo #(
    .W (FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_r),
    .push_data (push_word_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .not_empty (fifo_ne_s)
  );

  assign busy      = (state_r != RD_IDLE);
  assign done      = done_r;
  assign out_valid = fifo_ne_s;
  assign out_data  = head_s[DATA_W-1:0];
  assign out_index = head_s[DATA_W +: N_LOG2];
  assign out_last  = head_s[FW-1];

endmodule

// File: tb/tb_fft_output_reader.sv
// Bench for fft_output_reader: bank RAM model, scoreboard built from the
// natural-order data array, a cycle-timing table and corner-case sequences.
module tb_fft_output_reader;

  localparam int DATA_W = 32;
  localparam int N_LOG2 = 6;
  localparam int N      = 64;
  localparam int ADDR_W = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               busy, done;
  logic               re_b0, re_b1;
  logic [ADDR_W-1:0]  raddr_b0, raddr_b1;
  logic [DATA_W-1:0]  rdata_b0, rdata_b1;
  logic               out_valid, out_ready, out_last;
  logic [DATA_W-1:0]  out_data;
  logic [N_LOG2-1:0]  out_index;

  always #5 clk = ~clk;

  fft_output_reader #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .re_b0(re_b0), .raddr_b0(raddr_b0), .rdata_b0(rdata_b0),
    .re_b1(re_b1), .raddr_b1(raddr_b1), .rdata_b1(rdata_b1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );

  // Natural-order FFT output and the two physical banks holding it.
  logic [DATA_W-1:0] nat   [N];
  logic [DATA_W-1:0] bank0 [N/2];
  logic [DATA_W-1:0] bank1 [N/2];

  int vectors = 0;
  int miscompares = 0;

  function automatic int rev6(input int k);
    int r;
    r = 0;
    for (int b = 0; b < N_LOG2; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  function automatic int par(input int v);
    int c;
    c = 0;
    for (int b = 0; b < N_LOG2; b++) c = c + ((v >> b) & 1);
    return c % 2;
  endfunction

  task automatic preload(input int offs);
    for (int m = 0; m < N; m++) begin
      nat[m] = DATA_W'(m + offs);
      if (par(m) == 1) bank1[m / 2] = nat[m];
      else             bank0[m / 2] = nat[m];
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Synchronous-read SRAM banks, one cycle latency.
  always @(posedge clk) begin
    if (re_b0) rdata_b0 <= bank0[raddr_b0];
    if (re_b1) rdata_b1 <= bank1[raddr_b1];
  end

  // Scoreboard counters owned by the monitor; bases owned by the stimulus.
  int pop_cnt = 0, iss_cnt = 0, done_cnt = 0;
  int pop_base = 0, iss_base = 0;
  bit mon_en = 1'b0;

  // Monitor: expected sample for the next k, bank/address of every read,
  // and the bound on reads outstanding beyond pops.
  always @(negedge clk) begin : mon
    int k, ki, this_pop, this_iss, outstanding;
    if (mon_en) begin
      k        = (pop_cnt - pop_base) % N;
      this_pop = (out_valid && out_ready) ? 1 : 0;
      this_iss = (re_b0 || re_b1) ? 1 : 0;
      if (out_valid) begin
        check($sformatf("out_data k=%0d", k), 64'(out_data), 64'(nat[rev6(k)]));
        check($sformatf("out_index k=%0d", k), 64'(out_index), 64'(k));
        check($sformatf("out_last k=%0d", k), 64'(out_last), 64'(k == N - 1));
      end
      if (this_iss == 1) begin
        ki = (iss_cnt - iss_base) % N;
        check("re_both", 64'(re_b0 & re_b1), 64'd0);
        check($sformatf("read bank k=%0d", ki), 64'(re_b1), 64'(par(rev6(ki))));
        check($sformatf("read addr k=%0d", ki), 64'(re_b1 ? raddr_b1 : raddr_b0), 64'(rev6(ki) / 2));
        check($sformatf("idle bank addr k=%0d", ki), 64'(re_b1 ? raddr_b0 : raddr_b1), 64'd0);
        outstanding = (iss_cnt - iss_base + this_iss) - (pop_cnt - pop_base + this_pop);
        check("outstanding reads <= 2", 64'(outstanding <= 2), 64'd1);
      end
      pop_cnt  = pop_cnt + this_pop;
      iss_cnt  = iss_cnt + this_iss;
      if (done) done_cnt = done_cnt + 1;
    end
  end

  typedef struct {
    int           off;        // cycle t+off, t = cycle start is high
    logic         start_in;   // start driven for this cycle's closing edge
    logic         exp_valid;
    logic [5:0]   exp_index;
    logic         exp_last;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  vec_t tbl [12];

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int db, input string name);
    int c;
    c = 0;
    while (done_cnt == db && c < 1000) begin
      @(negedge clk); #1;
      c++;
    end
    check({name, " done seen"}, 64'(done_cnt - db), 64'd1);
  endtask

  initial begin
    int pb, db, c, phase;
    tbl[0]  = '{1,  1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0};
    tbl[1]  = '{2,  1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{3,  1'b0, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0};
    tbl[3]  = '{4,  1'b0, 1'b1, 6'd1,  1'b0, 1'b1, 1'b0};
    tbl[4]  = '{8,  1'b1, 1'b1, 6'd5,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{35, 1'b0, 1'b1, 6'd32, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{43, 1'b1, 1'b1, 6'd40, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{65, 1'b0, 1'b1, 6'd62, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{66, 1'b0, 1'b1, 6'd63, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{67, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1};
    tbl[10] = '{68, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0};
    tbl[11] = '{70, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    preload(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset re_b0", 64'(re_b0), 64'd0);
    check("reset re_b1", 64'(re_b1), 64'd0);
    check("reset raddr_b0", 64'(raddr_b0), 64'd0);
    check("reset raddr_b1", 64'(raddr_b1), 64'd0);
    check("reset out_index", 64'(out_index), 64'd0);
    check("reset out_last", 64'(out_last), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1 rst = 1'b0; mon_en = 1'b1;

    // Run A: full-rate timing table, with starts mid-run and on the done cycle.
    pb = pop_cnt; db = done_cnt;
    do_start();
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (tbl[i].off == cyc) begin
          check($sformatf("t+%0d out_valid", cyc), 64'(out_valid), 64'(tbl[i].exp_valid));
          check($sformatf("t+%0d busy", cyc), 64'(busy), 64'(tbl[i].exp_busy));
          check($sformatf("t+%0d done", cyc), 64'(done), 64'(tbl[i].exp_done));
          if (tbl[i].exp_valid) begin
            check($sformatf("t+%0d out_index", cyc), 64'(out_index), 64'(tbl[i].exp_index));
            check($sformatf("t+%0d out_last", cyc), 64'(out_last), 64'(tbl[i].exp_last));
          end
          start = tbl[i].start_in;
        end
      end
    end
    start = 1'b0;
    check("runA output count", 64'(pop_cnt - pb), 64'd64);
    check("runA done count", 64'(done_cnt - db), 64'd1);

    // Run B: out_ready pattern 1,0,0,1.
    pb = pop_cnt; db = done_cnt; phase = 0;
    do_start();
    c = 0;
    while (done_cnt == db && c < 1000) begin
      out_ready = (phase == 0 || phase == 3) ? 1'b1 : 1'b0;
      phase = (phase + 1) % 4;
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b1;
    check("runB done seen", 64'(done_cnt - db), 64'd1);
    check("runB output count", 64'(pop_cnt - pb), 64'd64);

    // Run C: reset in the cycle after output 20 handshakes, then restart.
    pb = pop_cnt;
    do_start();
    c = 0;
    while ((pop_cnt - pb) < 21 && c < 200) begin
      @(negedge clk); #1;
      c++;
    end
    check("runC reached output 20", 64'(pop_cnt - pb), 64'd21);
    @(posedge clk); #1 rst = 1'b1; mon_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    pop_base = pop_cnt; iss_base = iss_cnt; mon_en = 1'b1;
    @(negedge clk);
    check("post-reset busy", 64'(busy), 64'd0);
    check("post-reset out_valid", 64'(out_valid), 64'd0);
    check("post-reset re_b0", 64'(re_b0), 64'd0);
    check("post-reset re_b1", 64'(re_b1), 64'd0);
    check("post-reset done", 64'(done), 64'd0);
    pb = pop_cnt; db = done_cnt;
    do_start();
    c = 0;
    while (!out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("restart first out_data", 64'(out_data), 64'd0);
    check("restart first out_index", 64'(out_index), 64'd0);
    wait_done(db, "runC restart");
    check("runC restart output count", 64'(pop_cnt - pb), 64'd64);

    // Run D: new preload, start in the cycle right after done.
    preload(100);
    pb = pop_cnt; db = done_cnt;
    do_start();
    wait_done(db, "runD");
    check("runD output count", 64'(pop_cnt - pb), 64'd64);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_output_reader.md
Name: fft_output_reader

Overview:
- Unload side of the in-place 64-point radix-2 DIF FFT.
- After the last butterfly stage, reads the results out of the two dual-port SRAM banks (bank 0 / bank 1) in natural frequency order k = 0..63, undoing the bit-reversed in-place layout.
- Streams the results out on a valid/ready interface with full backpressure support.
- Owns only the read ports of both banks during unload; the FFT control block owns the write ports.

Parameters:
- DATA_W, 32, width of one complex sample (real/imag packed, 16+16).
- N_LOG2, 6, log2 of FFT size. Derived values: N = 2**N_LOG2, ADDR_W = N_LOG2-1 (bank address width, 5).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  single-cycle pulse; FFT results are complete in the banks
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse after the final output handshake
- re_b0  out  1  bank 0 read enable
- raddr_b0  out  ADDR_W  bank 0 read address
- rdata_b0  in  DATA_W  bank 0 read data, valid 1 cycle after re_b0
- re_b1  out  1  bank 1 read enable
- raddr_b1  out  ADDR_W  bank 1 read address
- rdata_b1  in  DATA_W  bank 1 read data, valid 1 cycle after re_b1
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the sample
- out_data  out  DATA_W  X[k]
- out_index  out  N_LOG2  k of the current sample
- out_last  out  1  high with k = N-1

Behaviour:
- Memory map (fixed):
  - X[k] sits at natural index m = bitrev(k), over N_LOG2 bits.
  - bank = XOR-reduce(m), which equals XOR-reduce(k).
  - address = m >> 1.
  - Only the selected bank's re is asserted; raddr of the unselected bank is 0.
- FSM IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: start is sampled; go to RUN with issue counter k_iss = 0.
  - RUN: issue one read per cycle when credit allows, incrementing k_iss. After the read for k = N-1 is issued, go to DRAIN.
  - DRAIN: no reads. Leave when the N-th output handshake (out_valid & out_ready & out_last) occurs. done = 1 in the following cycle; FSM returns to IDLE.
- Read latency: 1 cycle.
  - The bank-select bit and k are pipelined alongside the read.
  - In the cycle rdata returns, it is muxed by the delayed bank bit and pushed into a 2-entry output FIFO together with k and last.
- Credit rule: a read issues in a cycle only if fifo_count + inflight - pop < 2, where pop = out_valid & out_ready. This guarantees the FIFO never overflows and no read result is lost.
- out_valid = FIFO non-empty; outputs are driven from the FIFO head (registered).
  - With out_ready held high, throughput is 1 sample/cycle.
  - If start is seen at the clock edge ending cycle t, the first read issues in t+1, out_valid rises in t+3, out_last is in t+66, and done is in t+67.
- Backpressure: out_ready = 0 holds out_data/out_index/out_last stable while out_valid = 1. Reads stall by credit; no sample is dropped or duplicated.
- start while busy is ignored (no restart, no effect).
- start in the same cycle as done: done completes; start is ignored; a new start is needed from IDLE.
- rst (any state, including mid-run):
  - FSM goes to IDLE; k_iss = 0; FIFO is flushed; inflight is cleared.
  - busy = 0, done = 0, out_valid = 0, re_b0 = re_b1 = 0, raddr = 0, out_index = 0, out_last = 0, out_data = 0.
  - A read returning after reset is discarded.
- k counter wraps only by FSM exit; k_iss never exceeds N-1.

Decomposition:
- Shared package fft_pkg holds:
  - N_LOG2 default;
  - bitrev function (parametrised width);
  - bank-parity function (XOR-reduce);
  - address-from-index function (m >> 1).
  The FFT control block and this block share these functions.
- One natural sub-module: fft_out_fifo, a 2-entry synchronous FIFO with count output, simultaneous push/pop, and synchronous flush on rst.

Test Plan:
- Bench setup: the bench RAM model preloads natural index m with data = m (bank = parity(m), address = m>>1). The bench applies start and holds out_ready = 1.
  -> 64 samples arrive on consecutive cycles t+3..t+66.
  -> out_data sequence is 0, 32, 16, 48, 8, …, 63.
  -> out_index is 0..63.
  -> out_last only at index 63; done in t+67 only.
- Same preload; out_ready toggles 1,0,0,1 repeating.
  -> Same 64-value sequence, no drops or duplicates.
  -> Outputs are stable while stalled.
  -> At most 2 reads are outstanding beyond pops.
- Start pulses at outputs 5 and 40 of a run.
  -> Ignored: exactly 64 outputs and one done.
- rst asserted during the cycle after output 20 handshakes.
  -> Next cycle: busy = 0, out_valid = 0, re = 0.
  -> A fresh start yields the full sequence from k = 0 (out_data = 0).
- Start again the cycle after done; second run uses a new preload, data = m + 100.
  -> Second stream is 100, 132, 116, …, 163 with correct bank reads: k = 1 reads bank 1 address 16, and k = 3 reads bank 0 address 24.
